// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// the step-counter sizing helper.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter has to hold NSTEPS-1 without wrapping; one spare bit keeps
  // the NSTEPS=1 case at a legal, non-zero width.
  function automatic int cnt_width(input int width, input int step);
    return $clog2(width / step) + 1;
  endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// One-bit full-subtractor cell: d = x - y - br, with borrow-out bo.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ br;
  assign bo = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: a - b - bin over WIDTH bits, STEP bits per clock,
// LSB first, with a start/done handshake and signed-overflow flag.
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CW     = cnt_width(WIDTH, STEP);
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("serial_sub: WIDTH must be >= 2 and STEP must divide WIDTH");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             br_r;
  logic             a_msb;
  logic             b_msb;

  logic [STEP:0]    chain;
  logic [STEP-1:0]  step_d;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;

  // Ripple chain for this cycle's STEP bits, seeded by the carried borrow.
  assign chain[0] = br_r;

  for (genvar i = 0; i < STEP; i++) begin : g_cell
    fs_cell u_cell (
      .x  (a_sr[i]),
      .y  (b_sr[i]),
      .br (chain[i]),
      .d  (step_d[i]),
      .bo (chain[i+1])
    );
  end

  // New difference bits enter at the top so that after NSTEPS shifts the
  // first-computed (least significant) bits sit at the bottom.
  assign acc_next = WIDTH'({step_d, acc} >> STEP);
  assign ovf_next = (a_msb ^ b_msb) & (acc_next[WIDTH-1] ^ a_msb);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Control FSM with operand shifting, borrow carry and result publishing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      br_r  <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br_r  <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr <= a_sr >> STEP;
          b_sr <= b_sr >> STEP;
          br_r <= chain[STEP];
          acc  <= acc_next;
          if (cnt == LAST) begin
            diff  <= acc_next;
            bout  <= chain[STEP];
            ovf   <= ovf_next;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
